// File: rtl/mult_seq_if.sv
// Control/status bundle between the mult_seq sequencer and its add/shift datapath.
interface mult_seq_if #(
    parameter int N_BITS = 8
);
    localparam int IterW = $clog2(N_BITS) + 1;

    logic             Run;
    logic             ClearA_LoadB;
    logic             M;
    logic             LD_XA;
    logic             LD_B;
    logic             Shift_EN;
    logic             Clr_XA;
    logic             SUB_ADD;
    logic             Busy;
    logic             Done;
    logic [IterW-1:0] Iter;

    modport master (
        output Run, ClearA_LoadB, M,
        input  LD_XA, LD_B, Shift_EN, Clr_XA, SUB_ADD, Busy, Done, Iter
    );

    modport slave (
        input  Run, ClearA_LoadB, M,
        output LD_XA, LD_B, Shift_EN, Clr_XA, SUB_ADD, Busy, Done, Iter
    );
endinterface

// File: rtl/mult_seq.sv
// Booth-style signed add/shift multiplier sequencer for an external X:A:B datapath.
// Define MULT_SEQ_AUTOCLEAR_EN to clear X/A before every multiply (CLR state).
module mult_seq #(
    parameter int N_BITS = 8
) (
    input logic       Clk,
    input logic       Reset,
    mult_seq_if.slave bus
);
    localparam int IterW = $clog2(N_BITS) + 1;
    localparam logic [IterW-1:0] LastIter = IterW'(N_BITS - 1);
    localparam logic [IterW-1:0] NumIter  = IterW'(N_BITS);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoadB = 3'd1;
`ifdef MULT_SEQ_AUTOCLEAR_EN
    localparam logic [2:0] StClr   = 3'd2;
`endif
    localparam logic [2:0] StAdd   = 3'd3;
    localparam logic [2:0] StShift = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [IterW-1:0] iter_q, iter_d, iter_inc;

    assign iter_inc = iter_q + IterW'(1);

    always_comb begin
        state_d = state_q;
        iter_d  = iter_q;
        case (state_q)
            StIdle: begin
                // Load request outranks Run when both arrive together.
                if (bus.ClearA_LoadB) begin
                    state_d = StLoadB;
                end else if (bus.Run) begin
`ifdef MULT_SEQ_AUTOCLEAR_EN
                    state_d = StClr;
`else
                    state_d = StAdd;
`endif
                    iter_d  = '0;
                end
            end
            StLoadB: state_d = StIdle;
`ifdef MULT_SEQ_AUTOCLEAR_EN
            StClr: begin
                state_d = StAdd;
                iter_d  = '0;
            end
`endif
            StAdd:   state_d = StShift;
            StShift: begin
                iter_d  = iter_inc;
                state_d = (iter_inc == NumIter) ? StDone : StAdd;
            end
            // One multiply per press: wait for Run to drop.
            StDone:  if (!bus.Run) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
            iter_q  <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
        end
    end

    always_comb begin
        bus.LD_XA    = 1'b0;
        bus.LD_B     = 1'b0;
        bus.Shift_EN = 1'b0;
        bus.Clr_XA   = 1'b0;
        bus.SUB_ADD  = 1'b0;
        bus.Busy     = 1'b0;
        bus.Done     = 1'b0;
        case (state_q)
            StLoadB: begin
                bus.LD_B   = 1'b1;
                bus.Clr_XA = 1'b1;
            end
`ifdef MULT_SEQ_AUTOCLEAR_EN
            StClr: begin
                bus.Clr_XA = 1'b1;
                bus.Busy   = 1'b1;
            end
`endif
            StAdd: begin
                bus.LD_XA   = bus.M;
                // Last partial product carries the sign weight: subtract it.
                bus.SUB_ADD = (iter_q == LastIter);
                bus.Busy    = 1'b1;
            end
            StShift: begin
                bus.Shift_EN = 1'b1;
                bus.Busy     = 1'b1;
            end
            StDone:  bus.Done = 1'b1;
            default: ;
        endcase
    end

    assign bus.Iter = iter_q;
endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have parameter N_BITS, default 8, giving the operand width and the number of add/shift iterations.
REQ-002 SHALL have port Clk, input, 1 bit: the single system clock; all state updates occur on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Run, input, 1 bit: synchronized level that requests a multiply.
REQ-005 SHALL have port ClearA_LoadB, input, 1 bit: synchronized level that requests a load of B from the switches and a clear of X/A.
REQ-006 SHALL have port M, input, 1 bit: the current LSB of the B register.
REQ-007 SHALL have port LD_XA, output, 1 bit: load enable for the X/A registers from the adder.
REQ-008 SHALL have port LD_B, output, 1 bit: load enable for the B register.
REQ-009 SHALL have port Shift_EN, output, 1 bit: arithmetic right shift of X:A:B.
REQ-010 SHALL have port Clr_XA, output, 1 bit: synchronous clear of X and A.
REQ-011 SHALL have port SUB_ADD, output, 1 bit: selects subtract (1) or add (0) in the adder.
REQ-012 SHALL have port Busy, output, 1 bit: high while a multiply is in progress.
REQ-013 SHALL have port Done, output, 1 bit: high in the DONE state.
REQ-014 SHALL have port Iter, output, $clog2(N_BITS)+1 bits: current iteration index, for debug.

Function
REQ-015 SHALL implement the states IDLE, LOADB, CLR, ADD, SHIFT and DONE.
REQ-016 IDLE transitions: ClearA_LoadB=1 goes to LOADB; otherwise Run=1 goes to CLR (macro defined) or ADD (macro undefined); otherwise the FSM stays in IDLE.
REQ-017 When ClearA_LoadB=1 and Run=1 occur in the same IDLE cycle, ClearA_LoadB SHALL win.
REQ-018 LOADB SHALL assert LD_B=1 and Clr_XA=1 for exactly one cycle, then go to IDLE.
REQ-019 LOADB SHALL return to IDLE even if ClearA_LoadB is still held; repeated loads while the input is held are allowed.
REQ-020 CLR SHALL assert Clr_XA=1 for one cycle, then go to ADD with Iter=0.
REQ-021 ADD SHALL assert LD_XA=M for one cycle.
REQ-022 ADD SHALL assert SUB_ADD=1 only when Iter=N_BITS-1, and SUB_ADD=0 otherwise.
REQ-023 ADD SHALL always go to SHIFT next, whatever the value of M.
REQ-024 SHIFT SHALL assert Shift_EN=1 for one cycle.
REQ-025 On leaving SHIFT, Iter SHALL increment; when the new Iter equals N_BITS the FSM goes to DONE, otherwise to ADD.
REQ-026 Multiply latency SHALL be 2*N_BITS cycles of ADD/SHIFT, i.e. 16 cycles for N_BITS=8, plus 1 cycle when CLR is present.
REQ-027 DONE SHALL hold with all datapath enables low until Run=0, then go to IDLE, so exactly one multiply runs per press.
REQ-028 Busy SHALL be 1 in CLR, ADD and SHIFT, and 0 in all other states.
REQ-029 Run and ClearA_LoadB SHALL be ignored while Busy=1 or in DONE.
REQ-030 At most one of LD_XA, LD_B, Shift_EN SHALL be high in any cycle, with the single exception of LOADB driving LD_B together with Clr_XA.
REQ-031 Iter SHALL hold its value in DONE and SHALL be cleared to 0 on entry to ADD from IDLE or CLR.

Reset
REQ-032 Reset=0 SHALL asynchronously force state IDLE and Iter=0, with LD_XA, LD_B, Shift_EN, Clr_XA, SUB_ADD, Busy and Done all 0.
REQ-033 Reset mid-operation SHALL abort immediately, with no further enables issued; register contents are then undefined until the next LOADB.
REQ-034 After Reset is released, a Run already held high SHALL start a new multiply on the next edge.

Configuration
REQ-035 The feature SHALL be controlled by the macro MULT_SEQ_AUTOCLEAR_EN.
REQ-036 With MULT_SEQ_AUTOCLEAR_EN defined, every multiply SHALL pass through CLR, so X:A=0 at start and the result is a fresh product.
REQ-037 With MULT_SEQ_AUTOCLEAR_EN undefined, the CLR state SHALL not exist and IDLE goes straight to ADD.
REQ-038 With MULT_SEQ_AUTOCLEAR_EN undefined, A SHALL be retained, so consecutive Runs accumulate and continue multiplying the previous upper product; A is cleared only by LOADB.

Verification
REQ-039 Bench SHALL cover: LOADB with B=0x03, then Run with S=0x07 (macro defined) -> A:B=0x0015, Busy high for 17 cycles, then Done=1.
REQ-040 Bench SHALL cover: B=0xFF, S=0xFF (−1×−1) -> A:B=0x0001, with SUB_ADD=1 only in the 8th ADD.
REQ-041 Bench SHALL cover: B=0x80, S=0x80 (−128×−128) -> A:B=0x4000, X=0.
REQ-042 Bench SHALL cover: Run held high 40 cycles -> exactly one multiply, Done held until Run falls, and no second Busy.
REQ-043 Bench SHALL cover: ClearA_LoadB and Run asserted together in IDLE -> LOADB taken (LD_B=Clr_XA=1 for 1 cycle), and no Busy.
REQ-044 Bench SHALL cover: Reset=0 at the 5th SHIFT -> all outputs 0 the same cycle; after release with Run low, the FSM stays in IDLE.
